controller: RTL and testbench
=============================

// Module: controller
//
// PURPOSE
// Sequencing front end for the 4-bit ALU: one shared 4-bit input bus is captured
// over successive advance pulses as operand A, operand B, carry-in and opcode.
// The ALU operation then executes and the registered result is presented on
// out/cout. out_control_display drives user-visible step indicators (LEDs).
//
// PARAMETERS
// none; all widths fixed (4-bit datapath, 8-bit display).
//
// PORTS
// advance_signal       in   1  clock; all state/regs update on its rising edge
// reset_signal         in   1  asynchronous, active-high reset
// in                   in   4  shared input bus (A, B, cin in bit0, opcode)
// out                  out  4  registered ALU result
// cout                 out  1  registered carry/borrow out
// out_control_display  out  8  one-hot current-step indicator
//
// BEHAVIOUR
// - One clock (advance_signal); reset is asynchronous and active-high (reset_signal).
// - Reset: state=S_A; A, B, CIN, OP, out, cout = 0; display = 8'b0000_0001.
//   Reset asserted mid-sequence aborts immediately; captured values are discarded.
// - FSM, one transition per rising edge:
//   S_A:    A  <= in          -> S_B
//   S_B:    B  <= in          -> S_CIN
//   S_CIN:  CIN <= in[0]      -> S_OP   (in[3:1] ignored)
//   S_OP:   OP <= in          -> S_EXEC
//   S_EXEC: {cout,out} <= f(A,B,CIN,OP) -> S_SHOW
//   S_SHOW: no register change -> S_A (next sequence; out/cout hold)
// - out/cout change only in S_EXEC or reset; they hold through the next sequence.
// - display: bit0 S_A, bit1 S_B, bit2 S_CIN, bit3 S_OP, bit4 S_EXEC, bit5 S_SHOW;
//   bits 7:6 always 0. Exactly one bit set at all times after reset.
// - Opcodes (A,B unsigned 4-bit; 5-bit internal sum; cout = bit4 unless noted):
//   0000 A+B           0001 A-B (A+~B+1, cout=1 means no borrow)
//   0010 A&B           0011 A|B          0100 A^B        0101 ~A
//   0110 A+1           0111 A-1 (A+4'hF, cout=bit4)
//   1000 A<<1, cout=A[3]   1001 A>>1 logical, cout=A[0]
//   1010 A>>>1 arith, cout=A[0]            1011 ~(A&B)
//   1100 A+B+CIN       1101 A-B-~CIN (A+~B+CIN)
//   1110 pass A        1111 pass B
//   Logic/pass ops: cout=0.
// - Wrap-around: results truncated to 4 bits; overflow visible only via cout.
// - in may change at any time; only the value at the rising edge is captured.
//
// TESTING
// - Reset: reset_signal=1 -> out=0, cout=0, display=8'h01; release, no edges -> unchanged.
// - A=4'b1111, B=4'b0001, cin=1, OP=4'b1100, 5 edges -> out=4'b0001, cout=1, display=8'h20.
// - A=4'd9, B=4'd3, cin=x, OP=0001 -> out=4'd6, cout=1; B=4'd10 instead -> out=4'hF, cout=0.
// - A=4'b1010, OP=1010 (ASR) -> out=4'b1101, cout=0; OP=1000 -> out=4'b0100, cout=1.
// - Walk all 6 states: display one-hot 01,02,04,08,10,20, then 01 on sixth edge; out holds.
// - Assert reset while in S_OP after loading A/B -> state S_A, out=0, cout=0 immediately.

Source files
------------

// File: rtl/controller.sv
// Sequencing front end for the 4-bit ALU. The shared input bus is captured one field
// per advance_signal edge: A, B, carry-in, opcode. The next edge executes, the one after shows the result.
module controller (
   input  logic       advance_signal,
   input  logic       reset_signal,
   input  logic [3:0] in,
   output logic [3:0] out,
   output logic       cout,
   output logic [7:0] out_control_display
);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_CIN  = 3'd2,
      S_OP   = 3'd3,
      S_EXEC = 3'd4,
      S_SHOW = 3'd5
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [3:0] a_q;
   logic [3:0] b_q;
   logic       cin_q;
   logic [3:0] op_q;
   logic       load_a;
   logic       load_b;
   logic       load_cin;
   logic       load_op;
   logic       load_res;
   logic [4:0] alu_res;

   always_ff @(posedge advance_signal or posedge reset_signal) begin
      if (reset_signal) state_q <= S_A;
      else              state_q <= state_d;
   end

   always_comb begin
      state_d             = state_q;
      load_a              = 1'b0;
      load_b              = 1'b0;
      load_cin            = 1'b0;
      load_op             = 1'b0;
      load_res            = 1'b0;
      out_control_display = 8'h00;
      case (state_q)
         S_A: begin
            load_a              = 1'b1;
            out_control_display = 8'h01;
            state_d             = S_B;
         end
         S_B: begin
            load_b              = 1'b1;
            out_control_display = 8'h02;
            state_d             = S_CIN;
         end
         S_CIN: begin
            load_cin            = 1'b1;
            out_control_display = 8'h04;
            state_d             = S_OP;
         end
         S_OP: begin
            load_op             = 1'b1;
            out_control_display = 8'h08;
            state_d             = S_EXEC;
         end
         S_EXEC: begin
            load_res            = 1'b1;
            out_control_display = 8'h10;
            state_d             = S_SHOW;
         end
         S_SHOW: begin
            out_control_display = 8'h20;
            state_d             = S_A;
         end
         default: begin
            out_control_display = 8'h01;
            state_d             = S_A;
         end
      endcase
   end

   // Bit 4 of alu_res is the carry/borrow flag; logic and pass ops force it low.
   always_comb begin
      alu_res = 5'd0;
      case (op_q)
         4'b0000: alu_res = {1'b0, a_q} + {1'b0, b_q};
         4'b0001: alu_res = {1'b0, a_q} + {1'b0, ~b_q} + 5'd1;
         4'b0010: alu_res = {1'b0, a_q & b_q};
         4'b0011: alu_res = {1'b0, a_q | b_q};
         4'b0100: alu_res = {1'b0, a_q ^ b_q};
         4'b0101: alu_res = {1'b0, ~a_q};
         4'b0110: alu_res = {1'b0, a_q} + 5'd1;
         4'b0111: alu_res = {1'b0, a_q} + 5'h0F;
         4'b1000: alu_res = {a_q[3], a_q[2:0], 1'b0};
         4'b1001: alu_res = {a_q[0], 1'b0, a_q[3:1]};
         4'b1010: alu_res = {a_q[0], a_q[3], a_q[3:1]};
         4'b1011: alu_res = {1'b0, ~(a_q & b_q)};
         4'b1100: alu_res = {1'b0, a_q} + {1'b0, b_q} + {4'd0, cin_q};
         4'b1101: alu_res = {1'b0, a_q} + {1'b0, ~b_q} + {4'd0, cin_q};
         4'b1110: alu_res = {1'b0, a_q};
         4'b1111: alu_res = {1'b0, b_q};
         default: alu_res = 5'd0;
      endcase
   end

   always_ff @(posedge advance_signal or posedge reset_signal) begin
      if (reset_signal) begin
         a_q   <= 4'd0;
         b_q   <= 4'd0;
         cin_q <= 1'b0;
         op_q  <= 4'd0;
         out   <= 4'd0;
         cout  <= 1'b0;
      end else begin
         if (load_a)   a_q   <= in;
         if (load_b)   b_q   <= in;
         if (load_cin) cin_q <= in[0];
         if (load_op)  op_q  <= in;
         if (load_res) {cout, out} <= alu_res;
      end
   end

endmodule

// File: tb/tb_controller.sv
// Bench for controller: a table of hand-computed vectors, a randomised batch checked
// against an arithmetic reference model, and hand sequences for reset behaviour.
module tb_controller;

   logic       advance_signal = 1'b0;
   logic       reset_signal;
   logic [3:0] in;
   logic [3:0] out;
   logic       cout;
   logic [7:0] out_control_display;

   int tests  = 0;
   int errors = 0;

   logic [4:0] exp_q[$];
   logic [4:0] held;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic [3:0] op;
      logic [3:0] exp_out;
      logic       exp_cout;
   } vec_t;

   vec_t vecs[20];

   controller dut (
      .advance_signal      (advance_signal),
      .reset_signal        (reset_signal),
      .in                  (in),
      .out                 (out),
      .cout                (cout),
      .out_control_display (out_control_display)
   );

   // clock / reset
   always #5 advance_signal = ~advance_signal;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model written in integer arithmetic, independent of bit tricks.
   function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin, input logic [3:0] op);
      int   ai = int'(a);
      int   bi = int'(b);
      int   ci = int'(cin);
      int   r  = 0;
      logic c  = 1'b0;
      case (op)
         4'h0: begin r = ai + bi;            c = (ai + bi) >= 16;       end
         4'h1: begin r = ai - bi;            c = ai >= bi;              end
         4'h2: r = int'(a & b);
         4'h3: r = int'(a | b);
         4'h4: r = int'(a ^ b);
         4'h5: r = 15 - ai;
         4'h6: begin r = ai + 1;             c = ai == 15;              end
         4'h7: begin r = ai - 1;             c = ai != 0;               end
         4'h8: begin r = ai * 2;             c = ai >= 8;               end
         4'h9: begin r = ai / 2;             c = (ai % 2) == 1;         end
         4'hA: begin r = ai / 2 + ((ai >= 8) ? 8 : 0); c = (ai % 2) == 1; end
         4'hB: r = 15 - int'(a & b);
         4'hC: begin r = ai + bi + ci;       c = (ai + bi + ci) >= 16;  end
         4'hD: begin r = ai - bi - (1 - ci); c = ai >= bi + (1 - ci);   end
         4'hE: r = ai;
         default: r = bi;
      endcase
      return {c, r[3:0]};
   endfunction

   // driver: call between a falling and a rising edge while in S_A
   task automatic run_seq(input logic [3:0] a, input logic [3:0] b, input logic cin,
                          input logic [3:0] op, input logic [4:0] expv);
      logic [4:0] e;
      check("disp_a", out_control_display, 8'h01);
      check("hold_a", {3'b0, cout, out}, {3'b0, held});
      in = a;
      @(posedge advance_signal); @(negedge advance_signal);
      check("disp_b", out_control_display, 8'h02);
      in = b;
      @(posedge advance_signal); @(negedge advance_signal);
      check("disp_cin", out_control_display, 8'h04);
      in = {3'($urandom_range(0, 7)), cin};
      @(posedge advance_signal); @(negedge advance_signal);
      check("disp_op", out_control_display, 8'h08);
      check("hold_op", {3'b0, cout, out}, {3'b0, held});
      in = op;
      exp_q.push_back(expv);
      @(posedge advance_signal); @(negedge advance_signal);
      check("disp_exec", out_control_display, 8'h10);
      check("hold_exec", {3'b0, cout, out}, {3'b0, held});
      in = 4'($urandom_range(0, 15));
      @(posedge advance_signal); #1;
      check("disp_show", out_control_display, 8'h20);
      if (exp_q.size() == 0) begin
         tests++;
         errors++;
         $display("FAIL result_queue: got empty queue, expected one entry");
      end else begin
         e = exp_q.pop_front();
         check("result", {3'b0, cout, out}, {3'b0, e});
         held = e;
      end
      @(negedge advance_signal);
      in = 4'($urandom_range(0, 15));
      @(posedge advance_signal); #1;
      check("disp_wrap", out_control_display, 8'h01);
      check("hold_wrap", {3'b0, cout, out}, {3'b0, held});
      @(negedge advance_signal);
   endtask

   initial begin
      vecs[0]  = '{4'hF, 4'h1, 1'b1, 4'hC, 4'h1, 1'b1};
      vecs[1]  = '{4'h9, 4'h3, 1'b0, 4'h1, 4'h6, 1'b1};
      vecs[2]  = '{4'h9, 4'hA, 1'b1, 4'h1, 4'hF, 1'b0};
      vecs[3]  = '{4'hA, 4'h0, 1'b0, 4'hA, 4'hD, 1'b0};
      vecs[4]  = '{4'hA, 4'h0, 1'b0, 4'h8, 4'h4, 1'b1};
      vecs[5]  = '{4'h7, 4'h9, 1'b0, 4'h0, 4'h0, 1'b1};
      vecs[6]  = '{4'hC, 4'hA, 1'b0, 4'h2, 4'h8, 1'b0};
      vecs[7]  = '{4'hC, 4'hA, 1'b1, 4'h3, 4'hE, 1'b0};
      vecs[8]  = '{4'hC, 4'hA, 1'b0, 4'h4, 4'h6, 1'b0};
      vecs[9]  = '{4'h3, 4'h5, 1'b0, 4'h5, 4'hC, 1'b0};
      vecs[10] = '{4'hF, 4'h0, 1'b0, 4'h6, 4'h0, 1'b1};
      vecs[11] = '{4'h0, 4'h0, 1'b0, 4'h7, 4'hF, 1'b0};
      vecs[12] = '{4'h1, 4'h0, 1'b0, 4'h7, 4'h0, 1'b1};
      vecs[13] = '{4'h5, 4'h0, 1'b0, 4'h9, 4'h2, 1'b1};
      vecs[14] = '{4'hC, 4'hA, 1'b0, 4'hB, 4'h7, 1'b0};
      vecs[15] = '{4'h5, 4'h3, 1'b0, 4'hD, 4'h1, 1'b1};
      vecs[16] = '{4'h5, 4'h3, 1'b1, 4'hD, 4'h2, 1'b1};
      vecs[17] = '{4'h6, 4'h9, 1'b0, 4'hE, 4'h6, 1'b0};
      vecs[18] = '{4'h2, 4'hB, 1'b0, 4'hF, 4'hB, 1'b0};
      vecs[19] = '{4'h7, 4'h7, 1'b0, 4'h8, 4'hE, 1'b0};

      // reset state
      reset_signal = 1'b1;
      in           = 4'h0;
      held         = 5'd0;
      #2;
      check("rst_out", {4'b0, out}, 8'h00);
      check("rst_cout", {7'b0, cout}, 8'h00);
      check("rst_disp", out_control_display, 8'h01);
      @(negedge advance_signal);
      reset_signal = 1'b0;
      #1;
      check("rel_disp", out_control_display, 8'h01);
      check("rel_out", {3'b0, cout, out}, 8'h00);

      // table-driven vectors
      for (int i = 0; i < 20; i++)
         run_seq(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op,
                 {vecs[i].exp_cout, vecs[i].exp_out});

      // randomised sequences against the reference model
      for (int i = 0; i < 24; i++) begin
         logic [3:0] ra, rb, rop;
         logic       rc;
         ra  = 4'($urandom_range(0, 15));
         rb  = 4'($urandom_range(0, 15));
         rc  = 1'($urandom_range(0, 1));
         rop = 4'($urandom_range(0, 15));
         run_seq(ra, rb, rc, rop, model(ra, rb, rc, rop));
      end

      // make the held result non-zero so an abort is observable
      run_seq(4'h6, 4'h3, 1'b0, 4'h0, 5'h09);

      // reset while sitting in S_OP after loading A, B, cin
      in = 4'hF;
      @(posedge advance_signal); @(negedge advance_signal);
      in = 4'hF;
      @(posedge advance_signal); @(negedge advance_signal);
      in = 4'h1;
      @(posedge advance_signal); @(negedge advance_signal);
      check("mid_disp_op", out_control_display, 8'h08);
      reset_signal = 1'b1;
      #1;
      check("mid_rst_out", {4'b0, out}, 8'h00);
      check("mid_rst_cout", {7'b0, cout}, 8'h00);
      check("mid_rst_disp", out_control_display, 8'h01);
      @(negedge advance_signal);
      reset_signal = 1'b0;
      held = 5'd0;
      #1;
      check("mid_rel_disp", out_control_display, 8'h01);

      // captured operands must be discarded: pass B returns the new B, not stale 0xF
      run_seq(4'h2, 4'h4, 1'b0, 4'hF, 5'h04);
      run_seq(4'hA, 4'h0, 1'b0, 4'hA, 5'h0D);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
